// File: rtl/wishbone_multi_arbiter.sv
// rtl/wishbone_multi_arbiter.sv - N-master Wishbone B4 classic arbiter and bus mux
//
// Purpose:
//   Shares one downstream Wishbone bus between MASTERS upstream masters.
//   The grant is held for the whole cyc burst of the current owner. Handover
//   happens with zero idle cycles. A per-transfer stall watchdog answers a
//   hung slave with err.
//
// Configuration:
//   WB_ARB_ROUND_ROBIN_EN  defined   : round-robin search starting after the last owner
//                          undefined : fixed priority, lowest index wins
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we [MASTERS]       per-master bus controls
//   m_adr/m_o_dat/m_sel              packed per-master address, write data, byte selects
//   m_ack/m_err/m_rty [MASTERS]      per-master responses (owner only)
//   m_i_dat                          read data broadcast to all masters
//   wb_cyc/wb_stb/wb_we/wb_adr/
//   wb_o_dat/wb_sel                  downstream bus driven from the owner
//   wb_i_dat/wb_ack/wb_err/wb_rty    downstream read data and responses
//   o_grant [MASTERS]                registered one-hot owner, zero when idle

module wishbone_multi_arbiter #(
    parameter int MASTERS = 2,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [MASTERS-1:0]          m_cyc,
    input  logic [MASTERS-1:0]          m_stb,
    input  logic [MASTERS-1:0]          m_we,
    input  logic [MASTERS*ADDR_W-1:0]   m_adr,
    input  logic [MASTERS*DATA_W-1:0]   m_o_dat,
    input  logic [MASTERS*SEL_W-1:0]    m_sel,
    output logic [MASTERS-1:0]          m_ack,
    output logic [MASTERS-1:0]          m_err,
    output logic [MASTERS-1:0]          m_rty,
    output logic [DATA_W-1:0]           m_i_dat,
    output logic                        wb_cyc,
    output logic                        wb_stb,
    output logic                        wb_we,
    output logic [ADDR_W-1:0]           wb_adr,
    output logic [DATA_W-1:0]           wb_o_dat,
    output logic [SEL_W-1:0]            wb_sel,
    input  logic [DATA_W-1:0]           wb_i_dat,
    input  logic                        wb_ack,
    input  logic                        wb_err,
    input  logic                        wb_rty,
    output logic [MASTERS-1:0]          o_grant
);

    localparam int LW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic owned;
    logic stb_raw;
    logic wd_hit;
    logic any_resp;

    // The owner keeps the bus only while its own cyc is high; otherwise the
    // next edge re-arbitrates, which is what gives the zero-idle handover.
    assign owned    = |(grant_q & m_cyc);
    assign stb_raw  = |(grant_q & m_stb);
    assign any_resp = wb_ack | wb_err | wb_rty;
    assign wd_hit   = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        logic [LW:0]   sum;
        logic [LW-1:0] idx;
        logic          found;
        grant_d = grant_q;
        last_d  = last_q;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        if (!owned) begin
            grant_d = '0;
            for (int i = 0; i < MASTERS; i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                // Candidate order: last+1, last+2, ... wrapping modulo MASTERS.
                sum = {1'b0, last_q} + (LW+1)'(i + 1);
                if (sum >= (LW+1)'(MASTERS)) begin
                    sum = sum - (LW+1)'(MASTERS);
                end
                idx = sum[LW-1:0];
`else
                sum = '0;
                idx = LW'(i);
`endif
                if (!found && m_cyc[idx]) begin
                    found        = 1'b1;
                    grant_d[idx] = 1'b1;
                    last_d       = idx;
                end
            end
        end
    end

    // Stall counter: any cycle without a live strobe, or with a response,
    // restarts it. The timeout cycle itself has wb_stb forced low, so the
    // counter clears right after firing.
    always_comb begin
        if (!wb_stb || any_resp) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q <= '0;
            last_q  <= LW'(MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Downstream mux: an AND-OR over the one-hot grant yields zeros when idle.
    always_comb begin
        wb_we    = 1'b0;
        wb_adr   = '0;
        wb_o_dat = '0;
        wb_sel   = '0;
        for (int k = 0; k < MASTERS; k++) begin
            wb_we    = wb_we | (grant_q[k] & m_we[k]);
            wb_adr   = wb_adr   | ({ADDR_W{grant_q[k]}} & m_adr[k*ADDR_W +: ADDR_W]);
            wb_o_dat = wb_o_dat | ({DATA_W{grant_q[k]}} & m_o_dat[k*DATA_W +: DATA_W]);
            wb_sel   = wb_sel   | ({SEL_W{grant_q[k]}}  & m_sel[k*SEL_W +: SEL_W]);
        end
    end

    assign wb_cyc  = owned;
    assign wb_stb  = stb_raw & ~wd_hit;
    assign o_grant = grant_q;
    assign m_i_dat = wb_i_dat;

    // A genuine ack landing on the timeout cycle wins over the synthetic err.
    assign m_ack = grant_q & {MASTERS{wb_ack}};
    assign m_err = grant_q & {MASTERS{wb_err | (wd_hit & ~wb_ack)}};
    assign m_rty = grant_q & {MASTERS{wb_rty}};

endmodule
